// File: rtl/ext_ref_meter.sv
`timescale 1ns/1ps
// Period meter for an asynchronous external reference: synchronises ref_i, times the interval
// between rising edges in fpga_clk_i cycles, averages 2^AVG_LOG2 intervals and flags loss.
module ext_ref_meter #(
   parameter int CNT_WIDTH = 16,
   parameter int AVG_LOG2  = 2,
   parameter int TIMEOUT   = 4096
) (
   input  logic                 fpga_clk_i,
   input  logic                 rst_n_i,
   input  logic                 enable_i,
   input  logic                 ref_i,
   output logic                 edge_o,
   output logic [CNT_WIDTH-1:0] period_o,
   output logic                 period_valid_o,
   output logic                 lost_o
);
   localparam int SUM_W = CNT_WIDTH + AVG_LOG2;
   localparam int NS_W  = AVG_LOG2 + 1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);
   localparam logic [NS_W-1:0]      NS_ONE   = NS_W'(1);
   localparam logic [NS_W-1:0]      NS_LAST  = NS_W'((1 << AVG_LOG2) - 1);

   typedef enum logic [1:0] {IDLE, ACQUIRE, MEASURE} state_t;

   state_t               state_q, state_d;
   logic                 s1_q, s2_q, s3_q;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0] period_q, period_d;
   logic [SUM_W-1:0]     sum_q, sum_d;
   logic [NS_W-1:0]      nsamp_q, nsamp_d;
   logic                 valid_q, valid_d;
   logic                 lost_q, lost_d;
   logic [CNT_WIDTH-1:0] sample;
   logic [SUM_W-1:0]     sum_total;
   logic                 edge_w, timeout_w;

   assign edge_w    = s2_q & ~s3_q;
   assign timeout_w = (cnt_q == CNT_LAST);
   assign sample    = cnt_q + CNT_ONE;
   assign sum_total = sum_q + SUM_W'(sample);

   always_ff @(posedge fpga_clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         s3_q     <= 1'b0;
         state_q  <= IDLE;
         cnt_q    <= '0;
         sum_q    <= '0;
         nsamp_q  <= '0;
         period_q <= '0;
         valid_q  <= 1'b0;
         lost_q   <= 1'b0;
      end else begin
         s1_q     <= ref_i;
         s2_q     <= s1_q;
         s3_q     <= s2_q;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sum_q    <= sum_d;
         nsamp_q  <= nsamp_d;
         period_q <= period_d;
         valid_q  <= valid_d;
         lost_q   <= lost_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sum_d    = sum_q;
      nsamp_d  = nsamp_q;
      period_d = period_q;
      valid_d  = 1'b0;
      lost_d   = lost_q;
      if (!enable_i) begin
         state_d = IDLE;
         cnt_d   = '0;
         sum_d   = '0;
         nsamp_d = '0;
         lost_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = ACQUIRE;
               cnt_d   = '0;
            end
            ACQUIRE: begin
               // The first edge only starts timing; the loss timer keeps running until it arrives.
               if (edge_w) begin
                  state_d = MEASURE;
                  cnt_d   = '0;
                  sum_d   = '0;
                  nsamp_d = '0;
               end else if (timeout_w) begin
                  cnt_d  = '0;
                  lost_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            MEASURE: begin
               // An edge in the timeout cycle takes priority, so a period of exactly TIMEOUT is kept.
               if (edge_w) begin
                  cnt_d = '0;
                  if (nsamp_q == NS_LAST) begin
                     period_d = CNT_WIDTH'(sum_total >> AVG_LOG2);
                     valid_d  = 1'b1;
                     lost_d   = 1'b0;
                     sum_d    = '0;
                     nsamp_d  = '0;
                  end else begin
                     sum_d   = sum_total;
                     nsamp_d = nsamp_q + NS_ONE;
                  end
               end else if (timeout_w) begin
                  state_d = ACQUIRE;
                  cnt_d   = '0;
                  sum_d   = '0;
                  nsamp_d = '0;
                  lost_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign edge_o         = edge_w;
   assign period_o       = period_q;
   assign period_valid_o = valid_q;
   assign lost_o         = lost_q;

endmodule

// File: tb/tb_ext_ref_meter.sv
`timescale 1ns/1ps
// Directed and randomised bench for ext_ref_meter; expected results come from an edge-level model
// that derives periods from the reference rise times the bench itself generates.
module tb_ext_ref_meter;
   localparam int CW   = 16;
   localparam int TO_A = 4096;
   localparam int TO_B = 64;

   logic          clk = 1'b0;
   logic          rst_n, en_a, en_b, ref_in;
   logic          edge_a, valid_a, lost_a;
   logic [CW-1:0] period_a;
   logic          edge_b, valid_b, lost_b;
   logic [CW-1:0] period_b;

   int     n_checks = 0;
   int     n_errors = 0;
   longint cyc = 0;

   ext_ref_meter #(.CNT_WIDTH(CW), .AVG_LOG2(2), .TIMEOUT(TO_A)) u_dut (
      .fpga_clk_i(clk), .rst_n_i(rst_n), .enable_i(en_a), .ref_i(ref_in),
      .edge_o(edge_a), .period_o(period_a), .period_valid_o(valid_a), .lost_o(lost_a));

   ext_ref_meter #(.CNT_WIDTH(CW), .AVG_LOG2(2), .TIMEOUT(TO_B)) u_dut64 (
      .fpga_clk_i(clk), .rst_n_i(rst_n), .enable_i(en_b), .ref_i(ref_in),
      .edge_o(edge_b), .period_o(period_b), .period_valid_o(valid_b), .lost_o(lost_b));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Observation side: everything the DUTs do is logged here and compared in the main sequence.
   longint got_val_q[$];
   longint got_cyc_q[$];
   longint edge_cyc_q[$];
   longint b_val_q[$];
   int     edge_hi_cnt   = 0;
   int     lost_rises    = 0;
   int     b_lost_cycles = 0;
   longint lost_rise_cyc = -1;
   logic   lost_prev     = 1'b0;
   logic   edge_prev     = 1'b0;

   always @(negedge clk) begin
      if (edge_a) begin
         edge_hi_cnt++;
         if (!edge_prev) edge_cyc_q.push_back(cyc);
      end
      edge_prev = edge_a;
      if (valid_a) begin
         got_val_q.push_back(longint'(period_a));
         got_cyc_q.push_back(cyc);
      end
      if (lost_a && !lost_prev) begin
         lost_rises++;
         lost_rise_cyc = cyc;
      end
      lost_prev = lost_a;
      if (valid_b) b_val_q.push_back(longint'(period_b));
      if (lost_b) b_lost_cycles++;
   end

   // Reference model: a rise seen more than TO_A cycles after the previous one restarts acquisition.
   longint exp_val_q[$];
   longint exp_cyc_q[$];
   longint m_samps[$];
   bit     m_acq = 1'b0;
   bit     m_on  = 1'b1;
   longint m_last = 0;
   int     exp_rd = 0;
   int     got_rd = 0;
   longint last_rise = 0;
   int     n_rises = 0;

   task automatic model_rise(input longint c);
      longint s;
      if (m_acq && (c - m_last) > TO_A) m_acq = 1'b0;
      if (!m_acq) begin
         m_acq = 1'b1;
         m_samps.delete();
      end else begin
         m_samps.push_back(c - m_last);
         if (m_samps.size() == 4) begin
            s = 0;
            foreach (m_samps[k]) s += m_samps[k];
            exp_val_q.push_back(s / 4);
            exp_cyc_q.push_back(c + 3);
            m_samps.delete();
         end
      end
      m_last = c;
   endtask

   task automatic model_drop();
      m_acq = 1'b0;
      m_samps.delete();
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_checks++;
      assert (obs === exp_v)
      else begin
         n_errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   task automatic pulse(input int p);
      int h;
      h = p / 2;
      ref_in = 1'b1;
      n_rises++;
      last_rise = cyc;
      if (m_on) model_rise(cyc);
      repeat (h) @(negedge clk);
      ref_in = 1'b0;
      repeat (p - h) @(negedge clk);
   endtask

   function automatic logic [63:0] got_val(input int k);
      if (got_rd + k < got_val_q.size()) return got_val_q[got_rd + k];
      return '1;
   endfunction

   task automatic check_strobes(input string tag);
      int n_exp, n_got;
      #1;
      n_exp = exp_val_q.size() - exp_rd;
      n_got = got_val_q.size() - got_rd;
      chk({tag, "_strobe_count"}, n_got, n_exp);
      for (int i = 0; i < n_exp && i < n_got; i++) begin
         chk($sformatf("%s_val%0d", tag, i), got_val_q[got_rd + i], exp_val_q[exp_rd + i]);
         chk($sformatf("%s_cyc%0d", tag, i), got_cyc_q[got_rd + i], exp_cyc_q[exp_rd + i]);
      end
      exp_rd = exp_val_q.size();
      got_rd = got_val_q.size();
   endtask

   int     ph1[] = '{50, 50, 50, 50, 50, 50, 50, 50, 49, 51, 50, 52, 3, 3, 3, 4, 50, 50, 50, 50, 50};
   longint first_rise;
   int     b_vals_before;

   initial begin
      rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0; ref_in = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_edge", edge_a, 0);
      chk("rst_period", period_a, 0);
      chk("rst_valid", valid_a, 0);
      chk("rst_lost", lost_a, 0);
      rst_n = 1'b1;
      @(negedge clk);
      en_a = 1'b1;
      repeat (4) @(negedge clk);

      // Steady 50-cycle reference, then jittered sets, then a final 50-cycle set
      first_rise = cyc;
      foreach (ph1[k]) pulse(ph1[k]);
      #1;
      chk("edge_latency", edge_cyc_q.size() > 0 ? edge_cyc_q[0] : -1, first_rise + 2);
      chk("edge_width_total", edge_hi_cnt, n_rises);
      chk("steady_first_val", got_val(0), 50);
      chk("jitter_202_val", got_val(2), 50);
      chk("jitter_13_val", got_val(3), 3);
      chk("steady_no_lost", lost_rises, 0);
      check_strobes("steady");

      // Loss of reference after a result of 50
      for (int i = 0; i < TO_A + 500 && !lost_a; i++) @(negedge clk);
      #1;
      chk("loss_flag", lost_a, 1);
      chk("loss_time", lost_rise_cyc, last_rise + 2 + TO_A + 1);
      chk("loss_period_hold", period_a, 50);

      // Restart at 80: first edge only re-acquires, lost clears on the strobe
      repeat (4) pulse(80);
      #1;
      chk("restart_lost_held", lost_a, 1);
      pulse(80);
      #1;
      chk("restart_lost_clear", lost_a, 0);
      chk("restart_val", got_val(0), 80);
      check_strobes("restart");

      // Enable drop after two samples
      pulse(60);
      pulse(60);
      repeat (10) @(negedge clk);
      en_a = 1'b0;
      model_drop();
      repeat (20) @(negedge clk);
      #1;
      chk("endrop_period_hold", period_a, 80);
      chk("endrop_lost", lost_a, 0);
      check_strobes("endrop");
      @(negedge clk);
      en_a = 1'b1;
      repeat (4) @(negedge clk);
      repeat (5) pulse(40);
      #1;
      chk("reenable_val", got_val(0), 40);
      check_strobes("reenable");

      // Randomised periods
      for (int k = 0; k < 26; k++) pulse(int'($urandom_range(300, 3)));
      check_strobes("random");

      // Asynchronous reset between clock edges
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_edge", edge_a, 0);
      chk("arst_period", period_a, 0);
      chk("arst_valid", valid_a, 0);
      chk("arst_lost", lost_a, 0);
      @(negedge clk);
      rst_n = 1'b1;
      model_drop();
      repeat (4) @(negedge clk);
      chk("post_rst_period", period_a, 0);
      repeat (5) pulse(30);
      #1;
      chk("post_rst_val", got_val(0), 30);
      check_strobes("post_rst");

      // Edge landing in the cnt = TIMEOUT-1 cycle on the TIMEOUT=64 instance
      en_a = 1'b0;
      m_on = 1'b0;
      en_b = 1'b1;
      b_vals_before = b_val_q.size();
      repeat (4) @(negedge clk);
      repeat (5) pulse(TO_B);
      #1;
      chk("coll_strobe_count", b_val_q.size() - b_vals_before, 1);
      chk("coll_val", b_val_q.size() > b_vals_before ? b_val_q[b_vals_before] : -1, 64);
      chk("coll_no_lost", b_lost_cycles, 0);
      repeat (10) @(negedge clk);
      chk("coll_later_timeout", lost_b, 1);
      chk("coll_period_hold", period_b, 64);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
